// File: rtl/xor_parity_stream.sv
// Streaming frame parity generator/checker: XOR-reduces each beat, accumulates
// across a frame, reports parity/mismatch/beat count and counts error frames.
module xor_parity_stream #(
  parameter int WIDTH  = 8,
  parameter int ODD    = 0,
  parameter int CNT_W  = 8,
  parameter int ERRC_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              in_last,
  input  logic              in_par_exp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_par,
  output logic              out_err,
  output logic [CNT_W-1:0]  out_count,
  output logic [ERRC_W-1:0] out_err_cnt
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  localparam logic ODD_B = (ODD != 0);

  state_t           state;
  logic             acc;
  logic [CNT_W-1:0] cnt;

  logic             accept;
  logic             beat_par;
  logic             acc_next;
  logic [CNT_W-1:0] cnt_next;
  logic             par_next;
  logic             err_next;

  function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [ERRC_W-1:0] sat_err(input logic [ERRC_W-1:0] v);
    return (&v) ? v : v + ERRC_W'(1);
  endfunction

  assign in_ready = (state != HOLD);
  assign accept   = in_valid && in_ready;
  assign beat_par = ^in_data;
  // A beat taken in IDLE opens a new frame, so it restarts parity and count.
  assign acc_next = (state == IDLE) ? beat_par : (acc ^ beat_par);
  assign cnt_next = (state == IDLE) ? CNT_W'(1) : sat_cnt(cnt);
  assign par_next = acc_next ^ ODD_B;
  assign err_next = par_next ^ in_par_exp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      acc         <= 1'b0;
      cnt         <= '0;
      out_valid   <= 1'b0;
      out_par     <= 1'b0;
      out_err     <= 1'b0;
      out_count   <= '0;
      out_err_cnt <= '0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (accept) begin
            acc <= acc_next;
            cnt <= cnt_next;
            if (in_last) begin
              out_par   <= par_next;
              out_err   <= err_next;
              out_count <= cnt_next;
              out_valid <= 1'b1;
              if (err_next) out_err_cnt <= sat_err(out_err_cnt);
              state <= HOLD;
            end else begin
              state <= ACCUM;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xor_parity_stream.sv
// Randomized bench for xor_parity_stream: three instances (even, odd, narrow
// counters) share one stimulus stream and are checked against a frame-level model.
module tb_xor_parity_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_last, in_par_exp, out_ready;
  logic [7:0] in_data;

  always #5 clk = ~clk;

  logic       r0, v0, p0, e0, r1, v1, p1, e1, r2, v2, p2, e2;
  logic [7:0] c0, n0, c1, n1;
  logic [1:0] c2, n2;

  logic       rdy[3], ov[3], op[3], oe[3];
  logic [7:0] oc[3], oec[3];

  assign rdy[0] = r0; assign ov[0] = v0; assign op[0] = p0; assign oe[0] = e0;
  assign rdy[1] = r1; assign ov[1] = v1; assign op[1] = p1; assign oe[1] = e1;
  assign rdy[2] = r2; assign ov[2] = v2; assign op[2] = p2; assign oe[2] = e2;
  assign oc[0] = c0; assign oc[1] = c1; assign oc[2] = {6'b0, c2};
  assign oec[0] = n0; assign oec[1] = n1; assign oec[2] = {6'b0, n2};

  xor_parity_stream #(.WIDTH(8), .ODD(0), .CNT_W(8), .ERRC_W(8)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r0), .in_data(in_data),
    .in_last(in_last), .in_par_exp(in_par_exp), .out_valid(v0), .out_ready(out_ready),
    .out_par(p0), .out_err(e0), .out_count(c0), .out_err_cnt(n0));

  xor_parity_stream #(.WIDTH(8), .ODD(1), .CNT_W(8), .ERRC_W(8)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r1), .in_data(in_data),
    .in_last(in_last), .in_par_exp(in_par_exp), .out_valid(v1), .out_ready(out_ready),
    .out_par(p1), .out_err(e1), .out_count(c1), .out_err_cnt(n1));

  xor_parity_stream #(.WIDTH(8), .ODD(0), .CNT_W(2), .ERRC_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r2), .in_data(in_data),
    .in_last(in_last), .in_par_exp(in_par_exp), .out_valid(v2), .out_ready(out_ready),
    .out_par(p2), .out_err(e2), .out_count(c2), .out_err_cnt(n2));

  int checks = 0;
  int failures = 0;
  int oddk[3] = '{0, 1, 0};
  int cmax[3] = '{255, 255, 3};
  int emax[3] = '{255, 255, 3};
  int merr[3] = '{0, 0, 0};
  logic [7:0] bq[$];

  // Sends the frame held in bq, checks the result, stalls, then hands it off.
  task automatic run_frame(input logic exp, input int stall);
    int   waitc;
    int   n;
    logic xr;
    logic ep[3];
    logic ee[3];
    int   ec[3];
    waitc = 0;
    while (!rdy[0] && waitc < 50) begin
      @(posedge clk); #1;
      waitc++;
    end
    checks++;
    if (rdy[0] !== 1'b1) begin
      failures++;
      $display("FAIL frame_start_ready got=%b want=1", rdy[0]);
    end
    xr = 1'b0;
    n  = bq.size();
    for (int i = 0; i < n; i++) begin
      while (i > 0 && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0; in_data = 8'($urandom); in_last = 1'b1;
        @(posedge clk); #1;
      end
      in_valid   = 1'b1;
      in_data    = bq[i];
      in_last    = (i == n - 1);
      in_par_exp = (i == n - 1) ? exp : 1'($urandom);
      @(posedge clk); #1;
      for (int b = 0; b < 8; b++) xr = xr ^ bq[i][b];
    end
    in_valid = 1'b0; in_last = 1'b0;
    for (int k = 0; k < 3; k++) begin
      ep[k] = xr ^ (oddk[k] != 0);
      ee[k] = ep[k] ^ exp;
      ec[k] = (n > cmax[k]) ? cmax[k] : n;
      if (ee[k] && merr[k] < emax[k]) merr[k]++;
      checks++;
      if ({ov[k], op[k], oe[k], oc[k], oec[k], rdy[k]} !==
          {1'b1, ep[k], ee[k], 8'(ec[k]), 8'(merr[k]), 1'b0}) begin
        failures++;
        $display("FAIL result[%0d] got v/p/e/cnt/errcnt/rdy=%b/%b/%b/%0d/%0d/%b want=1/%b/%b/%0d/%0d/0",
                 k, ov[k], op[k], oe[k], oc[k], oec[k], rdy[k], ep[k], ee[k], ec[k], merr[k]);
      end
    end
    for (int s = 0; s < stall; s++) begin
      in_valid = 1'b1; in_data = 8'($urandom); in_last = 1'($urandom); in_par_exp = 1'($urandom);
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
        checks++;
        if ({ov[k], op[k], oe[k], oc[k], oec[k], rdy[k]} !==
            {1'b1, ep[k], ee[k], 8'(ec[k]), 8'(merr[k]), 1'b0}) begin
          failures++;
          $display("FAIL stall[%0d] cyc%0d got v/p/e/cnt/errcnt/rdy=%b/%b/%b/%0d/%0d/%b want=1/%b/%b/%0d/%0d/0",
                   k, s, ov[k], op[k], oe[k], oc[k], oec[k], rdy[k], ep[k], ee[k], ec[k], merr[k]);
        end
      end
    end
    // A beat offered on the handshake edge must not be taken.
    out_ready = 1'b1; in_valid = 1'b1; in_last = 1'b1; in_data = 8'($urandom);
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({ov[k], op[k], oe[k], oc[k], oec[k], rdy[k]} !==
          {1'b0, ep[k], ee[k], 8'(ec[k]), 8'(merr[k]), 1'b1}) begin
        failures++;
        $display("FAIL handoff[%0d] got v/p/e/cnt/errcnt/rdy=%b/%b/%b/%0d/%0d/%b want=0/%b/%b/%0d/%0d/1",
                 k, ov[k], op[k], oe[k], oc[k], oec[k], rdy[k], ep[k], ee[k], ec[k], merr[k]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({ov[k], op[k], oe[k], oc[k], oec[k], rdy[k]} !== {1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b1}) begin
        failures++;
        $display("FAIL reset[%0d] got v/p/e/cnt/errcnt/rdy=%b/%b/%b/%0d/%0d/%b want=0/0/0/0/0/1",
                 k, ov[k], op[k], oe[k], oc[k], oec[k], rdy[k]);
      end
      merr[k] = 0;
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_single();
    bq = '{8'hA5};
    run_frame(1'b0, 0);
  endtask

  task automatic test_multi();
    bq = '{8'h01, 8'h03, 8'h07};
    run_frame(1'b0, 0);
    bq = '{8'h01, 8'h03, 8'h07};
    run_frame(1'b1, 1);
  endtask

  task automatic test_odd();
    bq = '{8'h01};
    run_frame(1'b0, 0);
    bq = '{8'h00};
    run_frame(1'b0, 0);
  endtask

  task automatic test_stall();
    bq = '{8'h3C, 8'h81};
    run_frame(1'b1, 5);
  endtask

  task automatic test_saturate();
    bq = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
    run_frame(1'b0, 1);
    for (int f = 0; f < 5; f++) begin
      bq = '{8'h01};
      run_frame(1'b0, 0);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 8'h01; in_last = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({ov[k], op[k], oe[k], oc[k], oec[k], rdy[k]} !== {1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b1}) begin
        failures++;
        $display("FAIL async_reset[%0d] got v/p/e/cnt/errcnt/rdy=%b/%b/%b/%0d/%0d/%b want=0/0/0/0/0/1",
                 k, ov[k], op[k], oe[k], oc[k], oec[k], rdy[k]);
      end
      merr[k] = 0;
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    bq = '{8'h01};
    run_frame(1'b1, 0);
  endtask

  task automatic test_random();
    for (int f = 0; f < 25; f++) begin
      int len;
      len = $urandom_range(1, 10);
      bq = {};
      for (int i = 0; i < len; i++) bq.push_back(8'($urandom));
      run_frame(1'($urandom), $urandom_range(0, 3));
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_par_exp = 1'b0;
    in_data = 8'h00; out_ready = 1'b0;
    test_reset();
    test_single();
    test_multi();
    test_odd();
    test_stall();
    test_saturate();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
